// File: rtl/ee354_2048_pkg.sv
// Shared 2048 definitions: move direction codes and the move handshake state encoding.
package ee354_2048_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        MV_IDLE        = 2'b00,
        MV_PENDING     = 2'b01,
        MV_WAIT_ACK_LO = 2'b10
    } move_fsm_t;

endpackage

// File: rtl/btn_move_conditioner_if.sv
// Move-command handshake between the button conditioner (master) and the game FSM (slave).
interface btn_move_conditioner_if;
    import ee354_2048_pkg::*;

    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ack;
    logic [3:0] btn_level;
    logic       drop_pulse;

    modport master (
        output move_valid,
        output move_dir,
        output btn_level,
        output drop_pulse,
        input  move_ack
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        input  btn_level,
        input  drop_pulse,
        output move_ack
    );

endinterface

// File: rtl/btn_move_conditioner_debounce.sv
// One button: synchroniser chain, stable-run counter, debounced level and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic ClkPort,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // press is registered alongside the level so it coincides with the first cycle of btn_level=1
    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                btn_level <= ~btn_level;
                press     <= ~btn_level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_move_conditioner.sv
// Conditions four raw direction buttons into single move commands held on a 4-phase handshake.
module btn_move_conditioner
    import ee354_2048_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic ClkPort,
    input  logic rst,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    btn_move_conditioner_if.master mv
);

    logic [3:0]             raw;
    logic [3:0]             level;
    logic [3:0]             press;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   any_press;
    logic                   multi_press;
    logic [1:0]             win_dir;
    move_fsm_t              state;
    logic                   valid_q;
    logic [1:0]             dir_q;

    assign raw = {BtnU, BtnD, BtnL, BtnR};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_debounce (
            .ClkPort  (ClkPort),
            .rst      (rst),
            .btn_raw  (raw[i]),
            .btn_level(level[i]),
            .press    (press[i])
        );
    end

    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], mv.move_ack};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Fixed priority U > D > L > R; more than one set bit means someone loses
    always_comb begin
        win_dir = DIR_RIGHT;
        if (press[3]) begin
            win_dir = DIR_UP;
        end else if (press[2]) begin
            win_dir = DIR_DOWN;
        end else if (press[1]) begin
            win_dir = DIR_LEFT;
        end
        any_press   = |press;
        multi_press = (press & (press - 4'd1)) != 4'd0;
    end

    always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
            state   <= MV_IDLE;
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            case (state)
                MV_IDLE: begin
                    if (any_press) begin
                        dir_q   <= win_dir;
                        valid_q <= 1'b1;
                        state   <= MV_PENDING;
                    end
                end
                MV_PENDING: begin
                    if (ack_s) begin
                        valid_q <= 1'b0;
                        state   <= MV_WAIT_ACK_LO;
                    end
                end
                MV_WAIT_ACK_LO: begin
                    if (!ack_s) begin
                        state <= MV_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= MV_IDLE;
                end
            endcase
        end
    end

    assign mv.move_valid = valid_q;
    assign mv.move_dir   = dir_q;
    assign mv.btn_level  = level;
    assign mv.drop_pulse = any_press && (multi_press || (state != MV_IDLE));

endmodule

// File: tb/tb_btn_move_conditioner.sv
// Directed plus randomized bench for btn_move_conditioner against a window-based behavioural model.
module tb_btn_move_conditioner;

    localparam int D = 8;

    logic       ClkPort;
    logic       rst;
    logic [3:0] btns;
    logic       ack;

    int n_pass;
    int n_total;

    btn_move_conditioner_if bus();
    assign bus.move_ack = ack;

    btn_move_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4),
        .SYNC_STAGES    (2)
    ) dut (
        .ClkPort(ClkPort),
        .rst    (rst),
        .BtnU   (btns[3]),
        .BtnD   (btns[2]),
        .BtnL   (btns[1]),
        .BtnR   (btns[0]),
        .mv     (bus.master)
    );

    initial ClkPort = 1'b0;
    always #5 ClkPort = ~ClkPort;

    // Model: a button level flips once the last D synchronised samples all disagree with it
    bit [1:0]   m_rd  [4];
    bit [D-1:0] m_win [4];
    bit [3:0]   m_lvl;
    bit [3:0]   m_rise;
    bit [1:0]   m_ad;
    int         m_st;
    bit         m_valid;
    bit [1:0]   m_dir;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rd[i]  = '0;
            m_win[i] = '0;
        end
        m_lvl   = '0;
        m_rise  = '0;
        m_ad    = '0;
        m_st    = 0;
        m_valid = 1'b0;
        m_dir   = 2'd0;
    endtask

    task automatic model_step();
        bit ack_s;
        ack_s = m_ad[1];
        case (m_st)
            0: if (m_rise != 4'd0) begin
                for (int i = 0; i < 4; i++)
                    if (m_rise[i]) m_dir = 2'(3 - i);
                m_valid = 1'b1;
                m_st    = 1;
            end
            1: if (ack_s) begin
                m_valid = 1'b0;
                m_st    = 2;
            end
            default: if (!ack_s) m_st = 0;
        endcase
        for (int i = 0; i < 4; i++) begin
            m_win[i]  = {m_win[i][D-2:0], m_rd[i][1]};
            m_rise[i] = 1'b0;
            if (m_win[i] == (m_lvl[i] ? {D{1'b0}} : {D{1'b1}})) begin
                m_lvl[i]  = ~m_lvl[i];
                m_rise[i] = m_lvl[i];
            end
            m_rd[i] = {m_rd[i][0], btns[i]};
        end
        m_ad = {m_ad[0], ack};
    endtask

    function automatic bit model_drop();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_rise[i]);
        return (n > 1) || (m_st != 0 && n > 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge ClkPort);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("valid", 32'(bus.move_valid), 32'(m_valid));
        chk("dir",   32'(bus.move_dir),   32'(m_dir));
        chk("level", 32'(bus.btn_level),  32'(m_lvl));
        chk("drop",  32'(bus.drop_pulse), 32'(model_drop()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.move_valid && n < 60) begin
            tick();
            n++;
        end
        chk("wait_valid", 32'(bus.move_valid), 32'd1);
    endtask

    task automatic ack_cycle();
        int n;
        wait_valid();
        ack = 1'b1;
        n = 0;
        while (bus.move_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ack_drops_valid", 32'(bus.move_valid), 32'd0);
        ack = 1'b0;
        run(4);
    endtask

    initial begin
        int cnt;
        int drops;
        int nv;
        int cmds;
        bit prev;
        int hold [4];

        n_pass  = 0;
        n_total = 0;
        rst  = 1'b1;
        btns = '0;
        ack  = 1'b0;
        model_reset();
        #3;
        chk("rst_valid", 32'(bus.move_valid), 32'd0);
        chk("rst_dir",   32'(bus.move_dir),   32'd0);
        chk("rst_level", 32'(bus.btn_level),  32'd0);
        chk("rst_drop",  32'(bus.drop_pulse), 32'd0);
        run(2);
        rst = 1'b0;
        run(5);

        // bounce then hold
        for (int k = 0; k < 10; k++) begin
            btns[3] = ~btns[3];
            run(3);
        end
        btns[3] = 1'b1;
        cnt = 0;
        while (!bus.btn_level[3] && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("bounce_latency", 32'(cnt), 32'd10);
        tick();
        chk("bounce_valid", 32'(bus.move_valid), 32'd1);
        chk("bounce_dir",   32'(bus.move_dir),   32'd0);

        // handshake timing
        ack = 1'b1;
        run(2);
        chk("valid_hold", 32'(bus.move_valid), 32'd1);
        tick();
        chk("ack_fall_3", 32'(bus.move_valid), 32'd0);
        ack = 1'b0;
        run(3);
        btns[3] = 1'b0;
        run(15);
        btns[0] = 1'b1;
        wait_valid();
        chk("right_dir", 32'(bus.move_dir), 32'd3);
        ack_cycle();
        btns[0] = 1'b0;
        run(15);

        // simultaneous L and R
        btns[1] = 1'b1;
        btns[0] = 1'b1;
        drops = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            drops += int'(bus.drop_pulse);
        end
        chk("simul_drops", 32'(drops), 32'd1);
        chk("simul_dir",   32'(bus.move_dir), 32'd2);
        ack_cycle();
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            nv += int'(bus.move_valid);
        end
        chk("simul_no_second", 32'(nv), 32'd0);
        btns = '0;
        run(15);

        // held button
        btns[2] = 1'b1;
        cmds = 0;
        prev = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.move_valid && !prev) begin
                cmds++;
                chk("held_dir", 32'(bus.move_dir), 32'd1);
            end
            prev = bus.move_valid;
            ack  = bus.move_valid;
        end
        chk("held_cmds", 32'(cmds), 32'd1);
        ack = 1'b0;
        btns[2] = 1'b0;
        run(15);

        // press while pending
        btns[2] = 1'b1;
        wait_valid();
        btns[3] = 1'b1;
        drops = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            drops += int'(bus.drop_pulse);
        end
        chk("busy_drops", 32'(drops), 32'd1);
        chk("busy_dir",   32'(bus.move_dir), 32'd1);
        ack_cycle();
        btns = '0;
        run(15);

        // async reset while pending
        btns[1] = 1'b1;
        wait_valid();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.move_valid), 32'd0);
        chk("async_rst_level", 32'(bus.btn_level),  32'd0);
        btns = '0;
        run(3);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            nv += int'(bus.move_valid);
        end
        chk("post_rst_idle", 32'(nv), 32'd0);

        // randomized buttons and consumer
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    btns[i] = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 30));
                end else begin
                    hold[i]--;
                end
            end
            if (m_valid && !ack && $urandom_range(0, 3) == 0) ack = 1'b1;
            else if (!m_valid && ack && $urandom_range(0, 3) == 0) ack = 1'b0;
            else if (!m_valid && m_st == 0 && $urandom_range(0, 99) == 0) ack = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
